// File: rtl/gesture_word_streamer.sv
// gesture_word_streamer
// Turns an accepted gesture code into its ASCII word followed by a terminator
// byte. The word is right-justified in a CHARS-wide field padded with spaces.
// It is streamed leftmost byte first over a valid/ready byte interface.
// Optional build macro: GSW_TRIM_LEAD_EN skips the leading space padding.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a gesture code; code_ready high
// SEND  | presenting word byte at index cnt (down-counts to 0)
// TERM  | presenting EOL_CHAR with char_last high

module gesture_word_streamer #(
  parameter int         CHARS    = 6,
  parameter int         CODE_W   = 4,
  parameter logic [7:0] EOL_CHAR = 8'h0D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] gesture_code,
  input  logic              code_valid,
  output logic              code_ready,
  output logic [7:0]        char_out,
  output logic              char_valid,
  input  logic              char_ready,
  output logic              char_last,
  output logic              busy
);

  localparam int               CNT_W   = $clog2(CHARS);
  localparam int               WORD_W  = 8 * CHARS;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CHARS - 1);

  typedef enum logic [1:0] {IDLE, SEND, TERM} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [WORD_W-1:0] word_r, word_nxt;

  logic [7:0]        code_ext;
  logic              code_blank;
  logic [47:0]       raw6;
  logic [WORD_W-1:0] raw_word;
  logic [WORD_W-1:0] padded_word;
  logic [CNT_W-1:0]  start_idx;
  logic              accept;
  logic              hs;

  assign code_ext   = 8'(gesture_code);
  assign code_blank = (code_ext == 8'd0) || (code_ext >= 8'd16);

  // Word table: zero-padded ASCII, at most six characters per word
  always_comb begin
    raw6 = '0;
    case (code_ext)
      8'd1:    raw6 = {24'd0, "YES"};
      8'd2:    raw6 = {32'd0, "NO"};
      8'd3:    raw6 = {16'd0, "HELP"};
      8'd4:    raw6 = {8'd0,  "WATER"};
      8'd5:    raw6 = {16'd0, "FOOD"};
      8'd6:    raw6 = {16'd0, "PAIN"};
      8'd7:    raw6 = {16'd0, "STOP"};
      8'd8:    raw6 = {32'd0, "GO"};
      8'd9:    raw6 = {16'd0, "HOME"};
      8'd10:   raw6 = "HUNGRY";
      8'd11:   raw6 = "THIRST";
      8'd12:   raw6 = {16'd0, "CALL"};
      8'd13:   raw6 = {8'd0,  "EMERG"};
      8'd14:   raw6 = {32'd0, "OK"};
      8'd15:   raw6 = "THANKS";
      default: raw6 = '0;
    endcase
  end

  assign raw_word = WORD_W'(raw6);

  // Replace the zero fill on the left with ASCII spaces
  always_comb begin
    padded_word = '0;
    for (int i = 0; i < CHARS; i++) begin
      padded_word[8*i +: 8] = (raw_word[8*i +: 8] == 8'h00) ? 8'h20 : raw_word[8*i +: 8];
    end
  end

`ifdef GSW_TRIM_LEAD_EN
  // Highest byte index holding a non-space; words never contain spaces
  always_comb begin
    start_idx = '0;
    for (int i = 0; i < CHARS; i++) begin
      if (padded_word[8*i +: 8] != 8'h20) start_idx = CNT_W'(i);
    end
  end
`else
  assign start_idx = CNT_TOP;
`endif

  assign accept = code_valid && code_ready;
  assign hs     = char_valid && char_ready;

  // State, byte counter and latched word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= CNT_TOP;
      word_r <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      word_r <= word_nxt;
    end
  end

  // Next-state: blank codes are accepted but dropped while staying in IDLE
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    word_nxt  = word_r;
    case (state)
      IDLE: begin
        if (accept && !code_blank) begin
          state_nxt = SEND;
          word_nxt  = padded_word;
          cnt_nxt   = start_idx;
        end
      end
      SEND: begin
        if (hs) begin
          if (cnt == '0) state_nxt = TERM;
          else           cnt_nxt   = cnt - 1'b1;
        end
      end
      TERM: begin
        if (hs) begin
          state_nxt = IDLE;
          cnt_nxt   = CNT_TOP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode straight from registers, so they hold while stalled
  always_comb begin
    code_ready = (state == IDLE) && !rst;
    char_valid = (state == SEND) || (state == TERM);
    char_last  = (state == TERM);
    busy       = (state != IDLE);
    char_out   = 8'h00;
    case (state)
      SEND:    char_out = word_r[{cnt, 3'b000} +: 8];
      TERM:    char_out = EOL_CHAR;
      default: char_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_gesture_word_streamer.sv
module tb_gesture_word_streamer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       cv = 1'b0;
  logic       char_ready = 1'b1;
  logic [4:0] code_in = '0;

  always #5 clk = ~clk;

  logic       a_code_ready, a_char_valid, a_char_last, a_busy;
  logic [7:0] a_char_out;
  logic       b_code_ready, b_char_valid, b_char_last, b_busy;
  logic [7:0] b_char_out;

  gesture_word_streamer #(.CHARS(6), .CODE_W(4), .EOL_CHAR(8'h0D)) dut_a (
    .clk(clk), .rst(rst),
    .gesture_code(code_in[3:0]), .code_valid(cv & ~sel), .code_ready(a_code_ready),
    .char_out(a_char_out), .char_valid(a_char_valid), .char_ready(char_ready),
    .char_last(a_char_last), .busy(a_busy)
  );

  gesture_word_streamer #(.CHARS(8), .CODE_W(5), .EOL_CHAR(8'h0D)) dut_b (
    .clk(clk), .rst(rst),
    .gesture_code(code_in), .code_valid(cv & sel), .code_ready(b_code_ready),
    .char_out(b_char_out), .char_valid(b_char_valid), .char_ready(char_ready),
    .char_last(b_char_last), .busy(b_busy)
  );

  logic       m_code_ready, m_char_valid, m_char_last, m_busy;
  logic [7:0] m_char_out;
  assign m_code_ready = sel ? b_code_ready : a_code_ready;
  assign m_char_valid = sel ? b_char_valid : a_char_valid;
  assign m_char_last  = sel ? b_char_last  : a_char_last;
  assign m_busy       = sel ? b_busy       : a_busy;
  assign m_char_out   = sel ? b_char_out   : a_char_out;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; offers one code, then collects the stream
  task automatic send_word(input string tag, input logic [4:0] code,
                           input logic [7:0] exp_q[$], input int stall_idx);
    logic [7:0] got[$];
    int  cycles, gaps, last_cnt, last_pos, busy_bad, ready_bad;
    bit  done, stalled;
    got.delete();
    cycles = 0; gaps = 0; last_cnt = 0; last_pos = -1; busy_bad = 0; ready_bad = 0;
    done = 1'b0; stalled = 1'b0;
    check_val({tag, " code_ready"}, 32'(m_code_ready), 32'd1);
    code_in = code;
    cv = 1'b1;
    @(negedge clk);
    cv = 1'b0;
    while (!done && cycles < 60) begin
      if (got.size() == stall_idx && !stalled) begin
        stalled = 1'b1;
        char_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check_val({tag, " hold"}, {23'd0, m_char_valid, m_char_out},
                    {23'd0, 1'b1, exp_q[stall_idx]});
        end
        char_ready = 1'b1;
      end
      if (m_char_valid) begin
        got.push_back(m_char_out);
        if (!m_busy) busy_bad++;
        if (m_code_ready) ready_bad++;
        if (m_char_last) begin
          last_cnt++;
          last_pos = got.size() - 1;
          done = 1'b1;
        end
      end else begin
        gaps++;
      end
      @(negedge clk);
      cycles++;
    end
    check_val({tag, " done"}, 32'(done), 32'd1);
    check_val({tag, " count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check_val($sformatf("%s byte%0d", tag, i),
                (i < got.size()) ? {24'd0, got[i]} : 32'hFFFF_FFFF, {24'd0, exp_q[i]});
    end
    check_val({tag, " gaps"}, 32'(gaps), 32'd0);
    check_val({tag, " last_cnt"}, 32'(last_cnt), 32'd1);
    check_val({tag, " last_pos"}, 32'(last_pos), 32'(exp_q.size() - 1));
    check_val({tag, " busy_in_word"}, 32'(busy_bad), 32'd0);
    check_val({tag, " ready_in_word"}, 32'(ready_bad), 32'd0);
    check_val({tag, " idle_after"}, {30'd0, m_busy, m_code_ready}, {30'd0, 1'b0, 1'b1});
  endtask

  // Called at a negedge; offers a code that must be dropped
  task automatic send_blank(input string tag, input logic [4:0] code);
    code_in = code;
    cv = 1'b1;
    @(negedge clk);
    cv = 1'b0;
    check_val({tag, " valid"}, 32'(m_char_valid), 32'd0);
    check_val({tag, " ready"}, 32'(m_code_ready), 32'd1);
    check_val({tag, " busy"}, 32'(m_busy), 32'd0);
  endtask

  logic [7:0] exp_yes[$], exp_hungry[$], exp_no[$], exp_ok[$], exp_hungry8[$];
  int         valid_after_rst;

  initial begin
`ifdef GSW_TRIM_LEAD_EN
    exp_yes     = '{8'h59, 8'h45, 8'h53, 8'h0D};
    exp_no      = '{8'h4E, 8'h4F, 8'h0D};
    exp_ok      = '{8'h4F, 8'h4B, 8'h0D};
    exp_hungry8 = '{8'h48, 8'h55, 8'h4E, 8'h47, 8'h52, 8'h59, 8'h0D};
`else
    exp_yes     = '{8'h20, 8'h20, 8'h20, 8'h59, 8'h45, 8'h53, 8'h0D};
    exp_no      = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h4E, 8'h4F, 8'h0D};
    exp_ok      = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h4F, 8'h4B, 8'h0D};
    exp_hungry8 = '{8'h20, 8'h20, 8'h48, 8'h55, 8'h4E, 8'h47, 8'h52, 8'h59, 8'h0D};
`endif
    exp_hungry  = '{8'h48, 8'h55, 8'h4E, 8'h47, 8'h52, 8'h59, 8'h0D};

    #1;
    check_val("rst code_ready", 32'(a_code_ready), 32'd0);
    check_val("rst char_valid", 32'(a_char_valid), 32'd0);
    check_val("rst char_last", 32'(a_char_last), 32'd0);
    check_val("rst busy", 32'(a_busy), 32'd0);
    check_val("rst char_out", 32'(a_char_out), 32'd0);
    check_val("rst b code_ready", 32'(b_code_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    send_word("yes", 5'd1, exp_yes, -1);
    send_word("hungry", 5'd10, exp_hungry, -1);

    send_blank("blank0", 5'd0);
    send_word("no", 5'd2, exp_no, -1);

    // Abort THANKS while its fourth byte is on the bus
    code_in = 5'd15;
    cv = 1'b1;
    @(negedge clk);
    cv = 1'b0;
    repeat (3) @(negedge clk);
    check_val("abort byte4", {24'd0, a_char_out}, 32'h4E);
    rst = 1'b1;
    #1;
    check_val("abort valid", 32'(a_char_valid), 32'd0);
    check_val("abort last", 32'(a_char_last), 32'd0);
    check_val("abort busy", 32'(a_busy), 32'd0);
    check_val("abort out", 32'(a_char_out), 32'd0);
    check_val("abort ready", 32'(a_code_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    valid_after_rst = 0;
    repeat (3) begin
      @(negedge clk);
      if (a_char_valid) valid_after_rst++;
    end
    check_val("abort no_resume", 32'(valid_after_rst), 32'd0);
    send_word("ok", 5'd14, exp_ok, -1);

    sel = 1'b1;
    @(negedge clk);
    send_blank("blank16", 5'd16);
    send_blank("blank31", 5'd31);
    send_word("hungry8", 5'd10, exp_hungry8, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gesture_word_streamer.md
GESTURE_WORD_STREAMER -- requirements
Module: gesture_word_streamer

Interface
REQ-001 The block SHALL have parameter CHARS, default 6, giving the word field width in characters (legal range 6..16).
REQ-002 The block SHALL have parameter CODE_W, default 4, giving the gesture code width (legal range 4..8).
REQ-003 The block SHALL have parameter EOL_CHAR, default 8'h0D, giving the terminator byte sent after every word.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port gesture_code, input, CODE_W bits: the gesture code from the FSM.
REQ-007 The block SHALL have port code_valid, input, 1 bit: gesture_code is valid.
REQ-008 The block SHALL have port code_ready, output, 1 bit: the block accepts a code this cycle.
REQ-009 The block SHALL have port char_out, output, 8 bits: the ASCII byte.
REQ-010 The block SHALL have port char_valid, output, 1 bit: char_out is valid.
REQ-011 The block SHALL have port char_ready, input, 1 bit: the sink consumes char_out.
REQ-012 The block SHALL have port char_last, output, 1 bit: the current byte is the terminator.
REQ-013 The block SHALL have port busy, output, 1 bit: a word is in flight (state is not IDLE).

Function
REQ-014 The word table SHALL be: 1 YES, 2 NO, 3 HELP, 4 WATER, 5 FOOD, 6 PAIN, 7 STOP, 8 GO, 9 HOME, 10 HUNGRY, 11 THIRST, 12 CALL, 13 EMERG, 14 OK, 15 THANKS; each word is right-justified and left-padded with 8'h20 to CHARS.
REQ-015 Code 0, and every code of 16 or above, SHALL be treated as blank.
REQ-016 The FSM SHALL have three states: IDLE, SEND and TERM.
REQ-017 code_ready SHALL be 1 only in IDLE; a code is accepted on a clock edge where code_valid and code_ready are both 1.
REQ-018 An accepted non-blank code SHALL latch the padded word into an internal register and move to SEND; char_valid rises in the cycle after acceptance.
REQ-019 An accepted blank code SHALL be dropped: the FSM stays in IDLE, emits no bytes, and code_ready stays 1.
REQ-020 SEND SHALL present word bytes most-significant (leftmost) first, using a down-counter from CHARS-1 to 0.
REQ-021 The counter SHALL advance only on a handshake (char_valid and char_ready both 1).
REQ-022 The handshake on byte index 0 SHALL move the FSM to TERM.
REQ-023 TERM SHALL present EOL_CHAR with char_last=1; its handshake SHALL return the FSM to IDLE.
REQ-024 While char_ready=0, char_out, char_valid and char_last SHALL hold stable; the byte order SHALL never skip or repeat a byte.
REQ-025 A non-blank word SHALL take at least CHARS+1 cycles (CHARS+1 bytes); a new code is accepted no earlier than the cycle after the TERM handshake.
REQ-026 char_last SHALL be 0 in SEND and in IDLE.

Reset
REQ-027 On rst=1, outputs SHALL go immediately: code_ready=0, char_valid=0, char_last=0, busy=0, char_out=8'h00; FSM=IDLE; counter=CHARS-1; word register cleared.
REQ-028 After rst deasserts, code_ready SHALL be 1 from the first clock edge.
REQ-029 Reset in mid-word SHALL abort the word with no terminator; a partially sent word is not resumed.

Configuration
REQ-030 With GSW_TRIM_LEAD_EN defined, SEND SHALL start at the first non-space byte of the latched word, so no leading 8'h20 bytes are emitted; the first-byte latency is unchanged (one cycle after acceptance).
REQ-031 Without GSW_TRIM_LEAD_EN, all CHARS bytes including padding SHALL be emitted.

Verification
REQ-032 CHARS=6, no trim, char_ready=1, code 1 -> bytes 20 20 20 59 45 53 0D on 7 consecutive cycles; char_last only on 0D; busy for 7 cycles.
REQ-033 GSW_TRIM_LEAD_EN, code 1 -> bytes 59 45 53 0D; code 10 -> 48 55 4E 47 52 59 0D.
REQ-034 CHARS=8, code 10, char_ready held low for 3 cycles on the third byte -> byte 48 held stable for 3 cycles; stream 20 20 48 55 4E 47 52 59 0D with no loss or duplication.
REQ-035 code 0 with code_valid=1 -> no char_valid, code_ready stays 1; code 2 on the next cycle -> 20 20 20 20 4E 4F 0D.
REQ-036 rst pulsed during the 4th byte of code 15 -> char_valid=0 asynchronously, no 0D emitted; code 14 accepted next -> 20 20 20 20 4F 4B 0D.
